pool_window_stream: RTL and testbench

Streaming front end that drives the combinational maxpool2 block. Accepts a raster-order feature-map pixel stream (one pixel per beat) and buffers one row in a line buffer. On each odd-row, odd-column pixel it assembles the 2x2 window {row r-1, col c-1; row r-1, col c; row r, col c-1; row r, col c} and presents it to maxpool2. Emits one pooled pixel per window on a valid/ready output stream. It sits between the conv/activation output stream and the pooled-feature writer.

---
 rtl/pool_window_stream_pkg.sv | 20 ++
 rtl/pool_window_stream_maxpool2.sv | 18 +
 rtl/pool_window_stream.sv | 106 ++++++++++
 tb/tb_pool_window_stream.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_window_stream_pkg.sv
// Shared types and sizing helpers for the 2x2 pooling window streamer.
package pool_window_stream_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;

    typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;

    // What an accepted input beat does, decided by row/column parity.
    typedef enum logic [1:0] {
        BEAT_FILL,
        BEAT_HOLD,
        BEAT_EMIT
    } beat_e;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_window_stream_maxpool2.sv
// Combinational 2x2 unsigned maximum.
module maxpool2 #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [0:1][0:1][DATA_WIDTH-1:0] in,
    output logic [DATA_WIDTH-1:0]           out
);

    logic [DATA_WIDTH-1:0] top_max;
    logic [DATA_WIDTH-1:0] bot_max;

    always_comb begin
        top_max = (in[0][0] >= in[0][1]) ? in[0][0] : in[0][1];
        bot_max = (in[1][0] >= in[1][1]) ? in[1][0] : in[1][1];
        out     = (top_max >= bot_max) ? top_max : bot_max;
    end

endmodule

// File: rtl/pool_window_stream.sv
// Raster pixel stream -> 2x2 max-pooled stream, one line buffer, one output register.
module pool_window_stream
    import pool_window_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_W      = 8,
    parameter int unsigned IMG_H      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int unsigned COL_W = cnt_w(IMG_W);
    localparam int unsigned ROW_W = cnt_w(IMG_H);

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [COL_W-1:0]      col_left;
    logic [DATA_WIDTH-1:0] linebuf [IMG_W];
    logic [DATA_WIDTH-1:0] held;

    logic [0:1][0:1][DATA_WIDTH-1:0] win;
    logic [DATA_WIDTH-1:0]           win_max;

    beat_e beat;
    logic  accept;
    logic  col_end;
    logic  row_end;

    always_comb begin
        beat = BEAT_FILL;
        if (row[0]) begin
            beat = col[0] ? BEAT_EMIT : BEAT_HOLD;
        end

        // Only emit beats need the output register; everything else always flows.
        in_ready = (beat != BEAT_EMIT) || !out_valid || out_ready;
        accept   = in_valid && in_ready;

        col_end  = (col == COL_W'(IMG_W - 1));
        row_end  = (row == ROW_W'(IMG_H - 1));
        col_left = col - COL_W'(1);

        win[0][0] = linebuf[col_left];
        win[0][1] = linebuf[col];
        win[1][0] = held;
        win[1][1] = in_data;
    end

    maxpool2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_maxpool2 (
        .in (win),
        .out(win_max)
    );

    // Line buffer is deliberately left out of reset; every entry is rewritten before use.
    always_ff @(posedge clk) begin
        if (accept && (beat == BEAT_FILL)) begin
            linebuf[col] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            held      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end

                if (beat == BEAT_HOLD) begin
                    held <= in_data;
                end
            end

            // A new emit wins over a simultaneous drain of the previous result.
            if (accept && (beat == BEAT_EMIT)) begin
                out_valid <= 1'b1;
                out_data  <= win_max;
                out_last  <= row_end && col_end;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_data  <= '0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool_window_stream.sv
// Self-checking bench for pool_window_stream with a 4x4 frame.
module tb_pool_window_stream;
    import pool_window_stream_pkg::*;

    localparam int unsigned W    = 4;
    localparam int unsigned H    = 4;
    localparam int unsigned NPIX = W * H;
    localparam int unsigned NOUT = (W / 2) * (H / 2);

    logic   clk       = 1'b0;
    logic   rst_n     = 1'b0;
    logic   in_valid  = 1'b0;
    logic   in_ready;
    pixel_t in_data   = '0;
    logic   out_valid;
    logic   out_ready = 1'b1;
    pixel_t out_data;
    logic   out_last;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    pool_window_stream #(
        .DATA_WIDTH(8),
        .IMG_W     (W),
        .IMG_H     (H)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    typedef struct {
        pixel_t      pix [NPIX];
        pixel_t      exp [NOUT];
        int unsigned gap;
    } vec_t;

    vec_t        tbl [3];
    logic [8:0]  exp_q [$];
    int unsigned pix_idx  = 0;
    int          pending  = 0;
    int unsigned rdy_mode = 0;
    logic        mon_en   = 1'b0;
    logic        prev_stall = 1'b0;
    pixel_t      prev_data  = '0;
    logic        prev_last  = 1'b0;
    logic        took;
    logic        emitted;
    logic [8:0]  e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    function automatic logic is_emit(input int unsigned idx);
        return (((idx / W) % 2) == 1) && (((idx % W) % 2) == 1);
    endfunction

    function automatic pixel_t max4(input pixel_t a, input pixel_t b, input pixel_t c, input pixel_t d);
        pixel_t m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic model_frame(input pixel_t f [NPIX], output pixel_t o [NOUT]);
        for (int r = 0; r < int'(H / 2); r++) begin
            for (int c = 0; c < int'(W / 2); c++) begin
                o[r * int'(W / 2) + c] = max4(f[(2 * r) * W + 2 * c], f[(2 * r) * W + 2 * c + 1],
                                              f[(2 * r + 1) * W + 2 * c], f[(2 * r + 1) * W + 2 * c + 1]);
            end
        end
    endtask

    task automatic push_exp(input pixel_t o [NOUT]);
        for (int i = 0; i < int'(NOUT); i++) begin
            exp_q.push_back({(i == int'(NOUT) - 1), o[i]});
        end
    endtask

    // Handshake monitor with an occupancy model of the single output slot.
    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", 32'(out_valid), 32'(pending != 0));
            if (prev_stall) begin
                check("stall_data", 32'(out_data), 32'(prev_data));
                check("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (in_valid && rst_n) begin
                check("in_ready", 32'(in_ready),
                      32'(!is_emit(pix_idx) || (pending == 0) || out_ready));
            end
            took = out_valid && out_ready;
            if (took) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got data %0d want no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e[7:0]));
                    check("out_last", 32'(out_last), 32'(e[8]));
                end
            end
            emitted    = in_valid && in_ready && is_emit(pix_idx);
            pending    = pending + (emitted ? 1 : 0) - (took ? 1 : 0);
            prev_stall = rst_n && out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (!rst_n) pending = 0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_pixel(input pixel_t d, input int unsigned gap);
        int unsigned n;
        logic        acc;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        n        = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n >= 200) begin
                total++;
                bad++;
                $display("FAIL in_ready_timeout: got %0d stalled cycles want accept", n);
                break;
            end
        end
        in_valid = 1'b0;
        pix_idx  = (pix_idx + 1) % NPIX;
    endtask

    task automatic send_frame(input pixel_t f [NPIX], input int unsigned gapmax);
        for (int i = 0; i < int'(NPIX); i++) begin
            send_pixel(f[i], (gapmax == 0) ? 0 : $urandom_range(0, gapmax));
        end
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (((exp_q.size() != 0) || (pending != 0)) && (n < 400)) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("exp_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset(input int unsigned cycles);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        pix_idx = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        pixel_t      frm [NPIX];
        pixel_t      ref_o [NOUT];
        int unsigned n;
        int unsigned lowcnt;

        tbl[0].pix = '{3, 7, 10, 9, 2, 1, 8, 1, 0, 0, 255, 23, 0, 0, 44, 12};
        tbl[0].exp = '{7, 10, 0, 255};
        tbl[0].gap = 0;
        tbl[1].pix = '{200, 200, 200, 200, 200, 200, 200, 200, 200, 200, 200, 200, 200, 200, 200, 200};
        tbl[1].exp = '{200, 200, 200, 200};
        tbl[1].gap = 0;
        tbl[2].pix = '{8, 9, 0, 0, 10, 11, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8};
        tbl[2].exp = '{11, 0, 6, 8};
        tbl[2].gap = 3;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Basic frame, back-to-back 200 frame, gapped frame: one continuous stream.
        rdy_mode = 0;
        for (int t = 0; t < 3; t++) begin
            push_exp(tbl[t].exp);
            send_frame(tbl[t].pix, tbl[t].gap);
        end
        drain();

        // Backpressure while the first result of the frame is held.
        rdy_mode  = 2;
        out_ready = 1'b1;
        push_exp(tbl[0].exp);
        lowcnt = 0;
        fork
            send_frame(tbl[0].pix, 0);
            begin
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!(out_valid && (out_data == 8'd7)) && (n < 100));
                check("bp_found_7", 32'(out_valid && (out_data == 8'd7)), 32'd1);
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_hold_data", 32'(out_data), 32'd7);
                    check("bp_hold_valid", 32'(out_valid), 32'd1);
                    if (!in_ready) lowcnt++;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("bp_ready_low_cycles", 32'(lowcnt), 32'd4);
        drain();

        // Reset after 6 pixels; the result from pixel 5 is taken on the reset edge.
        rdy_mode = 0;
        exp_q.push_back({1'b0, 8'd7});
        for (int i = 0; i < 6; i++) send_pixel(tbl[0].pix[i], 0);
        do_reset(1);
        @(negedge clk);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        push_exp(tbl[2].exp);
        send_frame(tbl[2].pix, 3);
        drain();

        // Random frames against the reference model.
        rdy_mode = 1;
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < int'(NPIX); i++) begin
                frm[i] = pixel_t'($urandom_range(0, 255));
            end
            model_frame(frm, ref_o);
            push_exp(ref_o);
            send_frame(frm, 2);
        end
        drain();
        rdy_mode = 0;

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
